// File: rtl/ysyx_23060124_axi_arbiter_pkg.sv
// Shared types and defaults for the IFU/LSU to SRAM AXI arbiter.
// State encodings double as the externally visible grant code.
package ysyx_23060124_axi_arbiter_pkg;

   localparam int YSYX_23060124_ADDR_W = 32;
   localparam int YSYX_23060124_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IFU_RD = 2'd1,
      LSU_RD = 2'd2,
      LSU_WR = 2'd3
   } arb_state_e;

   // LSU write beats LSU read beats IFU, unless the IFU was just passed over
   function automatic arb_state_e pick_owner(
      input logic last_lsu,
      input logic ifu_req,
      input logic lsu_rd_req,
      input logic lsu_wr_req
   );
      if (last_lsu && ifu_req)
         return IFU_RD;
      else if (lsu_wr_req)
         return LSU_WR;
      else if (lsu_rd_req)
         return LSU_RD;
      else if (ifu_req)
         return IFU_RD;
      else
         return IDLE;
   endfunction

endpackage

// File: rtl/ysyx_23060124_axi_mux.sv
// Channel steering between the two upstream masters and the SRAM slave.
// Purely combinational; the owner and per-grant done flags come from the FSM.
module ysyx_23060124_axi_mux
   import ysyx_23060124_axi_arbiter_pkg::*;
#(
   parameter int ADDR_W = YSYX_23060124_ADDR_W,
   parameter int DATA_W = YSYX_23060124_DATA_W
) (
   input  arb_state_e          grant,
   input  logic                ar_done,
   input  logic                aw_done,
   input  logic                w_done,

   input  logic [ADDR_W-1:0]   ifu_araddr,
   input  logic                ifu_arvalid,
   output logic                ifu_arready,
   output logic [DATA_W-1:0]   ifu_rdata,
   output logic [1:0]          ifu_rresp,
   output logic                ifu_rvalid,
   input  logic                ifu_rready,

   input  logic [ADDR_W-1:0]   lsu_araddr,
   input  logic                lsu_arvalid,
   output logic                lsu_arready,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic [1:0]          lsu_rresp,
   output logic                lsu_rvalid,
   input  logic                lsu_rready,
   input  logic [ADDR_W-1:0]   lsu_awaddr,
   input  logic                lsu_awvalid,
   output logic                lsu_awready,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wstrb,
   input  logic                lsu_wvalid,
   output logic                lsu_wready,
   output logic [1:0]          lsu_bresp,
   output logic                lsu_bvalid,
   input  logic                lsu_bready,

   output logic [ADDR_W-1:0]   s_araddr,
   output logic                s_arvalid,
   input  logic                s_arready,
   input  logic [DATA_W-1:0]   s_rdata,
   input  logic [1:0]          s_rresp,
   input  logic                s_rvalid,
   output logic                s_rready,
   output logic [ADDR_W-1:0]   s_awaddr,
   output logic                s_awvalid,
   input  logic                s_awready,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_wstrb,
   output logic                s_wvalid,
   input  logic                s_wready,
   input  logic [1:0]          s_bresp,
   input  logic                s_bvalid,
   output logic                s_bready
);

   always_comb begin
      s_araddr    = '0;
      s_arvalid   = 1'b0;
      s_rready    = 1'b0;
      s_awaddr    = '0;
      s_awvalid   = 1'b0;
      s_wdata     = '0;
      s_wstrb     = '0;
      s_wvalid    = 1'b0;
      s_bready    = 1'b0;
      ifu_arready = 1'b0;
      ifu_rdata   = '0;
      ifu_rresp   = 2'b00;
      ifu_rvalid  = 1'b0;
      lsu_arready = 1'b0;
      lsu_rdata   = '0;
      lsu_rresp   = 2'b00;
      lsu_rvalid  = 1'b0;
      lsu_awready = 1'b0;
      lsu_wready  = 1'b0;
      lsu_bresp   = 2'b00;
      lsu_bvalid  = 1'b0;
      unique case (grant)
         IFU_RD: begin
            s_araddr    = ifu_araddr;
            s_arvalid   = ifu_arvalid && !ar_done;
            ifu_arready = s_arready && !ar_done;
            s_rready    = ifu_rready;
            ifu_rdata   = s_rdata;
            ifu_rresp   = s_rresp;
            ifu_rvalid  = s_rvalid;
         end
         LSU_RD: begin
            s_araddr    = lsu_araddr;
            s_arvalid   = lsu_arvalid && !ar_done;
            lsu_arready = s_arready && !ar_done;
            s_rready    = lsu_rready;
            lsu_rdata   = s_rdata;
            lsu_rresp   = s_rresp;
            lsu_rvalid  = s_rvalid;
         end
         LSU_WR: begin
            s_awaddr    = lsu_awaddr;
            s_awvalid   = lsu_awvalid && !aw_done;
            lsu_awready = s_awready && !aw_done;
            s_wdata     = lsu_wdata;
            s_wstrb     = lsu_wstrb;
            s_wvalid    = lsu_wvalid && !w_done;
            lsu_wready  = s_wready && !w_done;
            s_bready    = lsu_bready;
            lsu_bresp   = s_bresp;
            lsu_bvalid  = s_bvalid;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ysyx_23060124_axi_arbiter.sv
// Single-owner AXI arbiter: IFU read, LSU read and LSU write share one SRAM.
// Ownership is held until the response handshake, however long that takes.
module ysyx_23060124_axi_arbiter
   import ysyx_23060124_axi_arbiter_pkg::*;
#(
   parameter int ADDR_W = YSYX_23060124_ADDR_W,
   parameter int DATA_W = YSYX_23060124_DATA_W
) (
   input  logic                clk,
   input  logic                rst,

   input  logic [ADDR_W-1:0]   ifu_araddr,
   input  logic                ifu_arvalid,
   output logic                ifu_arready,
   output logic [DATA_W-1:0]   ifu_rdata,
   output logic [1:0]          ifu_rresp,
   output logic                ifu_rvalid,
   input  logic                ifu_rready,

   input  logic [ADDR_W-1:0]   lsu_araddr,
   input  logic                lsu_arvalid,
   output logic                lsu_arready,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic [1:0]          lsu_rresp,
   output logic                lsu_rvalid,
   input  logic                lsu_rready,
   input  logic [ADDR_W-1:0]   lsu_awaddr,
   input  logic                lsu_awvalid,
   output logic                lsu_awready,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wstrb,
   input  logic                lsu_wvalid,
   output logic                lsu_wready,
   output logic [1:0]          lsu_bresp,
   output logic                lsu_bvalid,
   input  logic                lsu_bready,

   output logic [ADDR_W-1:0]   s_araddr,
   output logic                s_arvalid,
   input  logic                s_arready,
   input  logic [DATA_W-1:0]   s_rdata,
   input  logic [1:0]          s_rresp,
   input  logic                s_rvalid,
   output logic                s_rready,
   output logic [ADDR_W-1:0]   s_awaddr,
   output logic                s_awvalid,
   input  logic                s_awready,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_wstrb,
   output logic                s_wvalid,
   input  logic                s_wready,
   input  logic [1:0]          s_bresp,
   input  logic                s_bvalid,
   output logic                s_bready,

   output logic [1:0]          grant
);

   arb_state_e state;
   logic       last_lsu;
   logic       ar_done;
   logic       aw_done;
   logic       w_done;
   logic       r_hs;
   logic       b_hs;

   assign grant = state;
   assign r_hs  = s_rvalid && s_rready;
   assign b_hs  = s_bvalid && s_bready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         last_lsu <= 1'b0;
         ar_done  <= 1'b0;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               state   <= pick_owner(last_lsu, ifu_arvalid, lsu_arvalid,
                                     lsu_awvalid || lsu_wvalid);
               ar_done <= 1'b0;
               aw_done <= 1'b0;
               w_done  <= 1'b0;
            end
            IFU_RD, LSU_RD: begin
               if (s_arvalid && s_arready)
                  ar_done <= 1'b1;
               if (r_hs) begin
                  state    <= IDLE;
                  last_lsu <= (state == LSU_RD);
               end
            end
            LSU_WR: begin
               if (s_awvalid && s_awready)
                  aw_done <= 1'b1;
               if (s_wvalid && s_wready)
                  w_done <= 1'b1;
               if (b_hs) begin
                  state    <= IDLE;
                  last_lsu <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   ysyx_23060124_axi_mux #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mux (
      .grant       (state),
      .ar_done     (ar_done),
      .aw_done     (aw_done),
      .w_done      (w_done),
      .ifu_araddr  (ifu_araddr),
      .ifu_arvalid (ifu_arvalid),
      .ifu_arready (ifu_arready),
      .ifu_rdata   (ifu_rdata),
      .ifu_rresp   (ifu_rresp),
      .ifu_rvalid  (ifu_rvalid),
      .ifu_rready  (ifu_rready),
      .lsu_araddr  (lsu_araddr),
      .lsu_arvalid (lsu_arvalid),
      .lsu_arready (lsu_arready),
      .lsu_rdata   (lsu_rdata),
      .lsu_rresp   (lsu_rresp),
      .lsu_rvalid  (lsu_rvalid),
      .lsu_rready  (lsu_rready),
      .lsu_awaddr  (lsu_awaddr),
      .lsu_awvalid (lsu_awvalid),
      .lsu_awready (lsu_awready),
      .lsu_wdata   (lsu_wdata),
      .lsu_wstrb   (lsu_wstrb),
      .lsu_wvalid  (lsu_wvalid),
      .lsu_wready  (lsu_wready),
      .lsu_bresp   (lsu_bresp),
      .lsu_bvalid  (lsu_bvalid),
      .lsu_bready  (lsu_bready),
      .s_araddr    (s_araddr),
      .s_arvalid   (s_arvalid),
      .s_arready   (s_arready),
      .s_rdata     (s_rdata),
      .s_rresp     (s_rresp),
      .s_rvalid    (s_rvalid),
      .s_rready    (s_rready),
      .s_awaddr    (s_awaddr),
      .s_awvalid   (s_awvalid),
      .s_awready   (s_awready),
      .s_wdata     (s_wdata),
      .s_wstrb     (s_wstrb),
      .s_wvalid    (s_wvalid),
      .s_wready    (s_wready),
      .s_bresp     (s_bresp),
      .s_bvalid    (s_bvalid),
      .s_bready    (s_bready)
   );

endmodule

// File: tb/tb_ysyx_23060124_axi_arbiter.sv
// Bench for the AXI arbiter: behavioural SRAM slave, IFU/LSU drivers,
// and queue scoreboards for read data, write responses and grant order.
module tb_ysyx_23060124_axi_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ifu_araddr;
   logic        ifu_arvalid, ifu_arready;
   logic [31:0] ifu_rdata;
   logic [1:0]  ifu_rresp;
   logic        ifu_rvalid, ifu_rready;
   logic [31:0] lsu_araddr;
   logic        lsu_arvalid, lsu_arready;
   logic [31:0] lsu_rdata;
   logic [1:0]  lsu_rresp;
   logic        lsu_rvalid, lsu_rready;
   logic [31:0] lsu_awaddr;
   logic        lsu_awvalid, lsu_awready;
   logic [31:0] lsu_wdata;
   logic [3:0]  lsu_wstrb;
   logic        lsu_wvalid, lsu_wready;
   logic [1:0]  lsu_bresp;
   logic        lsu_bvalid, lsu_bready;
   logic [31:0] s_araddr;
   logic        s_arvalid, s_arready;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rvalid, s_rready;
   logic [31:0] s_awaddr;
   logic        s_awvalid;
   logic        s_awready;
   logic [31:0] s_wdata;
   logic [3:0]  s_wstrb;
   logic        s_wvalid;
   logic        s_wready;
   logic [1:0]  s_bresp;
   logic        s_bvalid, s_bready;
   logic [1:0]  grant;

   int checks = 0;
   int errors = 0;

   logic [33:0] ifu_q[$];
   logic [33:0] lsu_q[$];
   logic [1:0]  b_q[$];
   logic [1:0]  g_q[$];

   ysyx_23060124_axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid),
      .ifu_arready(ifu_arready), .ifu_rdata(ifu_rdata),
      .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid),
      .ifu_rready(ifu_rready),
      .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid),
      .lsu_arready(lsu_arready), .lsu_rdata(lsu_rdata),
      .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid),
      .lsu_rready(lsu_rready),
      .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid),
      .lsu_awready(lsu_awready), .lsu_wdata(lsu_wdata),
      .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid),
      .lsu_wready(lsu_wready), .lsu_bresp(lsu_bresp),
      .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid),
      .s_arready(s_arready), .s_rdata(s_rdata),
      .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid),
      .s_awready(s_awready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .grant(grant)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h5A5A_1234);
   endfunction

   function automatic logic [1:0] resp_of(input logic [31:0] a);
      return (a[31:28] == 4'hA) ? 2'b10 : 2'b00;
   endfunction

   // behavioural SRAM slave
   int          lat = 3;
   int          rd_cnt;
   logic        rd_pend;
   logic [31:0] rd_addr;
   logic        aw_got, w_got;
   logic [31:0] wr_addr, wr_data;
   logic [3:0]  wr_strb;
   int          ar_hs = 0, aw_hs = 0, w_hs = 0;

   assign s_arready = !rd_pend;
   assign s_awready = 1'b1;
   assign s_wready  = 1'b1;

   always @(posedge clk) begin
      if (rst) begin
         rd_pend  <= 1'b0;
         s_rvalid <= 1'b0;
         s_rdata  <= '0;
         s_rresp  <= 2'b00;
         aw_got   <= 1'b0;
         w_got    <= 1'b0;
         s_bvalid <= 1'b0;
         s_bresp  <= 2'b00;
      end else begin
         if (s_arvalid && s_arready) begin
            rd_pend <= 1'b1;
            rd_addr <= s_araddr;
            rd_cnt  <= lat;
            ar_hs   <= ar_hs + 1;
         end
         if (rd_pend && !s_rvalid) begin
            if (rd_cnt == 0) begin
               s_rvalid <= 1'b1;
               s_rdata  <= mem_data(rd_addr);
               s_rresp  <= resp_of(rd_addr);
            end else begin
               rd_cnt <= rd_cnt - 1;
            end
         end
         if (s_rvalid && s_rready) begin
            s_rvalid <= 1'b0;
            rd_pend  <= 1'b0;
         end
         if (s_awvalid && s_awready) begin
            aw_got  <= 1'b1;
            wr_addr <= s_awaddr;
            aw_hs   <= aw_hs + 1;
         end
         if (s_wvalid && s_wready) begin
            w_got   <= 1'b1;
            wr_data <= s_wdata;
            wr_strb <= s_wstrb;
            w_hs    <= w_hs + 1;
         end
         if (aw_got && w_got && !s_bvalid) begin
            s_bvalid <= 1'b1;
            s_bresp  <= resp_of(wr_addr);
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
         end
         if (s_bvalid && s_bready)
            s_bvalid <= 1'b0;
      end
   end

   // scoreboard monitor
   logic [1:0]  prev_grant = 2'd0;
   logic [33:0] exp34;
   logic [1:0]  exp2;

   always @(negedge clk) begin
      if (!rst) begin
         if (ifu_rvalid && ifu_rready) begin
            checks++;
            if (ifu_q.size() == 0) begin
               errors++;
               $display("FAIL ifu_unexpected_r got %h", ifu_rdata);
            end else begin
               exp34 = ifu_q.pop_front();
               if ({ifu_rresp, ifu_rdata} !== exp34) begin
                  errors++;
                  $display("FAIL ifu_rdata got %h want %h",
                           {ifu_rresp, ifu_rdata}, exp34);
               end
            end
         end
         if (lsu_rvalid && lsu_rready) begin
            checks++;
            if (lsu_q.size() == 0) begin
               errors++;
               $display("FAIL lsu_unexpected_r got %h", lsu_rdata);
            end else begin
               exp34 = lsu_q.pop_front();
               if ({lsu_rresp, lsu_rdata} !== exp34) begin
                  errors++;
                  $display("FAIL lsu_rdata got %h want %h",
                           {lsu_rresp, lsu_rdata}, exp34);
               end
            end
         end
         if (lsu_bvalid && lsu_bready) begin
            checks++;
            if (b_q.size() == 0) begin
               errors++;
               $display("FAIL lsu_unexpected_b got %h", lsu_bresp);
            end else begin
               exp2 = b_q.pop_front();
               if (lsu_bresp !== exp2) begin
                  errors++;
                  $display("FAIL lsu_bresp got %h want %h", lsu_bresp, exp2);
               end
            end
         end
         if (grant != 2'd0 && prev_grant == 2'd0) begin
            checks++;
            if (g_q.size() == 0) begin
               errors++;
               $display("FAIL grant_unexpected got %0d", grant);
            end else begin
               exp2 = g_q.pop_front();
               if (grant !== exp2) begin
                  errors++;
                  $display("FAIL grant_order got %0d want %0d", grant, exp2);
               end
            end
         end
         if (grant == 2'd0) begin
            checks++;
            if ({s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready} !== 5'b0) begin
               errors++;
               $display("FAIL idle_quiet got %b want 00000",
                        {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready});
            end
         end
         checks++;
         if ((grant != 2'd1 && (ifu_arready || ifu_rvalid)) ||
             (grant != 2'd2 && (lsu_arready || lsu_rvalid)) ||
             (grant != 2'd3 && (lsu_awready || lsu_wready || lsu_bvalid))) begin
            errors++;
            $display("FAIL non_owner_quiet grant %0d got active handshake line",
                     grant);
         end
      end
      prev_grant = grant;
   end

   task automatic rd(input bit lsu, input logic [31:0] addr);
      bit hs_ar, hs_r;
      if (lsu) begin
         lsu_q.push_back({resp_of(addr), mem_data(addr)});
         lsu_araddr = addr; lsu_arvalid = 1'b1; lsu_rready = 1'b1;
      end else begin
         ifu_q.push_back({resp_of(addr), mem_data(addr)});
         ifu_araddr = addr; ifu_arvalid = 1'b1; ifu_rready = 1'b1;
      end
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         hs_ar = lsu ? (lsu_arvalid && lsu_arready) : (ifu_arvalid && ifu_arready);
         hs_r  = lsu ? (lsu_rvalid && lsu_rready) : (ifu_rvalid && ifu_rready);
         @(posedge clk); #1;
         if (hs_ar) begin
            if (lsu) lsu_arvalid = 1'b0; else ifu_arvalid = 1'b0;
         end
         if (hs_r) begin
            if (lsu) lsu_rready = 1'b0; else ifu_rready = 1'b0;
            return;
         end
      end
      checks++; errors++;
      $display("FAIL rd_timeout lsu=%0d addr %h got no response want one", lsu, addr);
      if (lsu) begin lsu_arvalid = 1'b0; lsu_rready = 1'b0; end
      else begin ifu_arvalid = 1'b0; ifu_rready = 1'b0; end
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, input int lead);
      bit hs_aw, hs_w, hs_b;
      b_q.push_back(resp_of(addr));
      lsu_awaddr = addr; lsu_wdata = data; lsu_wstrb = strb;
      lsu_wvalid = 1'b1; lsu_awvalid = (lead == 0); lsu_bready = 1'b1;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         hs_aw = lsu_awvalid && lsu_awready;
         hs_w  = lsu_wvalid && lsu_wready;
         hs_b  = lsu_bvalid && lsu_bready;
         @(posedge clk); #1;
         if (hs_aw) lsu_awvalid = 1'b0;
         if (hs_w) lsu_wvalid = 1'b0;
         if (n + 1 == lead) lsu_awvalid = 1'b1;
         if (hs_b) begin
            lsu_bready = 1'b0;
            return;
         end
      end
      checks++; errors++;
      $display("FAIL wr_timeout addr %h got no bvalid want one", addr);
      lsu_awvalid = 1'b0; lsu_wvalid = 1'b0; lsu_bready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1; ifu_rready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (grant !== 2'd0 || s_arvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold got grant %0d arvalid %b want 0 0",
                     grant, s_arvalid);
         end
      end
      rst = 1'b0;
      g_q.push_back(2'd1);
      @(posedge clk); #1;
      checks++;
      if (grant !== 2'd1) begin
         errors++;
         $display("FAIL reset_first_grant got %0d want 1", grant);
      end
   endtask

   task automatic test_ifu_read();
      lat = 3;
      rd(1'b0, 32'h8000_0000);
      checks++;
      if (grant !== 2'd0) begin
         errors++;
         $display("FAIL ifu_back_idle got %0d want 0", grant);
      end
      lat = 1;
      g_q.push_back(2'd1);
      rd(1'b0, 32'hA000_0010);
   endtask

   task automatic test_contention();
      lat = 2;
      g_q.push_back(2'd2);
      g_q.push_back(2'd1);
      fork
         rd(1'b0, 32'h8000_0100);
         rd(1'b1, 32'h8000_0200);
      join
   endtask

   task automatic test_write_w_first();
      int a0, w0;
      a0 = aw_hs; w0 = w_hs;
      g_q.push_back(2'd3);
      wr(32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 2);
      checks++;
      if (aw_hs - a0 != 1 || w_hs - w0 != 1) begin
         errors++;
         $display("FAIL wr_hs_count got aw %0d w %0d want 1 1",
                  aw_hs - a0, w_hs - w0);
      end
      checks++;
      if ({wr_addr, wr_data, wr_strb} !== {32'h8000_1000, 32'hDEAD_BEEF, 4'hF}) begin
         errors++;
         $display("FAIL wr_fwd got %h %h %h want 80001000 deadbeef f",
                  wr_addr, wr_data, wr_strb);
      end
      checks++;
      if (grant !== 2'd0) begin
         errors++;
         $display("FAIL wr_back_idle got %0d want 0", grant);
      end
      g_q.push_back(2'd3);
      wr(32'hA000_2000, 32'h1234_5678, 4'h3, 0);
   endtask

   task automatic test_starvation();
      g_q.push_back(2'd1);
      g_q.push_back(2'd2);
      fork
         rd(1'b0, 32'h8000_0300);
         rd(1'b1, 32'h8000_0400);
      join
   endtask

   task automatic test_back_to_back();
      int a0;
      a0 = ar_hs;
      for (int i = 0; i < 4; i++) begin
         lat = $urandom_range(0, 4);
         g_q.push_back(2'd2);
         rd(1'b1, 32'h8000_2000 + 32'($urandom_range(0, 255)) * 4);
      end
      checks++;
      if (ar_hs - a0 != 4) begin
         errors++;
         $display("FAIL b2b_ar_count got %0d want 4", ar_hs - a0);
      end
   endtask

   task automatic test_mid_reset();
      bit seen;
      seen = 1'b0;
      lat = 10;
      g_q.push_back(2'd2);
      lsu_araddr = 32'h8000_3000; lsu_arvalid = 1'b1; lsu_rready = 1'b1;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         if (lsu_rvalid) seen = 1'b1;
         @(posedge clk); #1;
         if (grant == 2'd2 && !s_arvalid) lsu_arvalid = 1'b0;
      end
      checks++;
      if (grant !== 2'd2) begin
         errors++;
         $display("FAIL mid_reset_owner got %0d want 2", grant);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      lsu_arvalid = 1'b0;
      checks++;
      if (grant !== 2'd0 || s_arvalid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_idle got grant %0d arvalid %b want 0 0",
                  grant, s_arvalid);
      end
      for (int n = 0; n < 15; n++) begin
         @(negedge clk);
         if (lsu_rvalid) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL mid_reset_rvalid got 1 want 0");
      end
      lsu_rready = 1'b0;
      lat = 1;
      g_q.push_back(2'd2);
      g_q.push_back(2'd1);
      fork
         rd(1'b0, 32'h8000_0500);
         rd(1'b1, 32'h8000_0600);
      join
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      ifu_araddr = '0; ifu_arvalid = 1'b0; ifu_rready = 1'b0;
      lsu_araddr = '0; lsu_arvalid = 1'b0; lsu_rready = 1'b0;
      lsu_awaddr = '0; lsu_awvalid = 1'b0;
      lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 1'b0;
      lsu_bready = 1'b0;
      test_reset();
      test_ifu_read();
      test_contention();
      test_write_w_first();
      test_starvation();
      test_back_to_back();
      test_mid_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (ifu_q.size() + lsu_q.size() + b_q.size() + g_q.size() != 0) begin
         errors++;
         $display("FAIL leftover got %0d %0d %0d %0d want 0 0 0 0",
                  ifu_q.size(), lsu_q.size(), b_q.size(), g_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
